// File: rtl/jr_pc_redirect.sv
// JR redirect unit: hazard-aware resolution of register-indirect jumps in ID,
// forwarding the target from MEM/WB and steering the fetch PC.
//
// state   | meaning
// RUN     | normal sequential fetch, or JR resolved this cycle
// JR_WAIT | JR held in ID waiting for its rs producer to become forwardable
module jr_pc_redirect (
  input  logic        clk,
  input  logic        reset,
  input  logic        jr_control,
  input  logic [4:0]  jr_rs,
  input  logic [31:0] jr_rs_data,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_write_reg,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_write_reg,
  input  logic [31:0] mem_alu_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  input  logic        stall_in,
  output logic [31:0] pc,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        jr_misaligned,
  output logic [15:0] jr_count
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] JR_WAIT = 1'b1;

  logic [0:0]  state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] target;
  logic        rs_nz;
  logic        hazard;
  logic        fwd_mem;
  logic        fwd_wb;
  logic        resolve;

  assign rs_nz   = (jr_rs != 5'd0);
  // A load in MEM has no data yet; anything in EX has no data yet.
  assign hazard  = rs_nz && ((ex_reg_write && (ex_write_reg == jr_rs)) ||
                             (mem_mem_read && (mem_write_reg == jr_rs)));
  assign fwd_mem = rs_nz && mem_reg_write && !mem_mem_read && (mem_write_reg == jr_rs);
  assign fwd_wb  = rs_nz && wb_reg_write && (wb_write_reg == jr_rs);
  assign target  = fwd_mem ? mem_alu_result :
                   fwd_wb  ? wb_write_data  : jr_rs_data;
  assign resolve = jr_control && !hazard && !stall_in;

  always_comb begin
    pc_nxt       = pc + 32'd4;
    state_nxt    = RUN;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (resolve) begin
      pc_nxt      = {target[31:2], 2'b00};
      if_id_flush = 1'b1;
    end else if (jr_control && hazard) begin
      pc_nxt       = pc;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      state_nxt    = JR_WAIT;
    end else if (stall_in) begin
      pc_nxt      = pc;
      if_id_write = 1'b0;
      // a JR killed upstream while waiting drops back to RUN
      state_nxt   = jr_control ? state : RUN;
    end
    if (!reset) begin
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      pc            <= 32'h0000_0000;
      jr_count      <= 16'h0000;
      jr_misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (resolve) begin
        jr_count <= jr_count + 16'd1;
        if (target[1:0] != 2'b00) jr_misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jr_pc_redirect.sv
// Bench for jr_pc_redirect: directed scenarios plus random traffic checked
// against a stage-level model of when a JR's rs value is usable.
module tb_jr_pc_redirect;

  logic        clk = 1'b0;
  logic        reset;
  logic        jr_control;
  logic [4:0]  jr_rs;
  logic [31:0] jr_rs_data;
  logic        ex_reg_write;
  logic [4:0]  ex_write_reg;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_alu_result;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        stall_in;
  logic [31:0] pc;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        jr_misaligned;
  logic [15:0] jr_count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_mis;

  jr_pc_redirect dut (
    .clk(clk), .reset(reset), .jr_control(jr_control), .jr_rs(jr_rs),
    .jr_rs_data(jr_rs_data), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_write_reg(mem_write_reg), .mem_alu_result(mem_alu_result),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .stall_in(stall_in), .pc(pc),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .jr_misaligned(jr_misaligned), .jr_count(jr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, obs, exp);
  endtask

  task automatic idle();
    jr_control = 0; jr_rs = 0; jr_rs_data = 0;
    ex_reg_write = 0; ex_write_reg = 0;
    mem_reg_write = 0; mem_mem_read = 0; mem_write_reg = 0; mem_alu_result = 0;
    wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
    stall_in = 0;
  endtask

  // The value rs will hold once the youngest older writer retires, if that
  // writer already has its result; otherwise the JR must wait.
  task automatic ref_view(output bit ready, output logic [31:0] value);
    bit in_ex, load_mem, alu_mem, in_wb;
    in_ex    = ex_reg_write && ex_write_reg == jr_rs;
    load_mem = mem_mem_read && mem_write_reg == jr_rs;
    alu_mem  = mem_reg_write && !mem_mem_read && mem_write_reg == jr_rs;
    in_wb    = wb_reg_write && wb_write_reg == jr_rs;
    if (jr_rs == 0) begin
      ready = 1; value = jr_rs_data;
    end else begin
      ready = !(in_ex || load_mem);
      value = alu_mem ? mem_alu_result : (in_wb ? wb_write_data : jr_rs_data);
    end
  endtask

  // Check one cycle's combinational outputs and registered state, then clock.
  task automatic step(input string tag);
    bit ready, go, hold_jr;
    logic [31:0] value;
    #1;
    ref_view(ready, value);
    go      = reset && jr_control && ready && !stall_in;
    hold_jr = reset && jr_control && !ready;
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".cnt"}, {16'h0, jr_count}, {16'h0, m_cnt});
    chk({tag, ".mis"}, {31'h0, jr_misaligned}, {31'h0, m_mis});
    chk({tag, ".flush"}, {31'h0, if_id_flush}, {31'h0, go});
    chk({tag, ".bubble"}, {31'h0, id_ex_bubble}, {31'h0, hold_jr});
    chk({tag, ".ifidw"}, {31'h0, if_id_write},
        {31'h0, !reset || go || (!hold_jr && !stall_in)});
    @(posedge clk);
    if (!reset) begin
      m_pc = 0; m_cnt = 0; m_mis = 0;
    end else if (go) begin
      m_pc = value & 32'hFFFF_FFFC;
      m_cnt = m_cnt + 16'd1;
      if (value % 4 != 0) m_mis = 1;
    end else if (!hold_jr && !stall_in) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    m_pc = 0; m_cnt = 0; m_mis = 0;
    chk("rst.pc", pc, 32'h0);
    chk("rst.ifidw", {31'h0, if_id_write}, 32'h1);
    chk("rst.flush", {31'h0, if_id_flush}, 32'h0);
    chk("rst.bubble", {31'h0, id_ex_bubble}, 32'h0);
    @(posedge clk); #1;
    chk("rst.hold_pc", pc, 32'h0);
    reset = 1;
  endtask

  initial begin
    idle();
    reset = 0;
    m_pc = 0; m_cnt = 0; m_mis = 0;
    // reset dominates even a resolvable JR and a hazard
    jr_control = 1; jr_rs = 5; ex_reg_write = 1; ex_write_reg = 5;
    #2;
    chk("por.pc", pc, 32'h0);
    chk("por.cnt", {16'h0, jr_count}, 32'h0);
    chk("por.mis", {31'h0, jr_misaligned}, 32'h0);
    chk("por.ifidw", {31'h0, if_id_write}, 32'h1);
    chk("por.bubble", {31'h0, id_ex_bubble}, 32'h0);
    #10;
    idle();
    reset = 1;

    // sequential fetch
    step("seq0"); step("seq1");
    chk("seq.pc8", pc, 32'h8);

    // JR $31 to 0x40, no hazard
    jr_control = 1; jr_rs = 31; jr_rs_data = 32'h40;
    step("jr31");
    idle();
    chk("jr31.pc", pc, 32'h40);
    chk("jr31.cnt", {16'h0, jr_count}, 32'h1);
    step("jr31.after");

    // lw $5 in EX, then in MEM, then result via WB
    jr_control = 1; jr_rs = 5; jr_rs_data = 32'hDEAD_0000;
    ex_reg_write = 1; ex_write_reg = 5;
    step("lw.ex");
    ex_reg_write = 0; mem_reg_write = 1; mem_mem_read = 1; mem_write_reg = 5;
    mem_alu_result = 32'h1234;
    step("lw.mem");
    mem_reg_write = 0; mem_mem_read = 0;
    wb_reg_write = 1; wb_write_reg = 5; wb_write_data = 32'h100;
    step("lw.wb");
    chk("lw.pc", pc, 32'h100);
    idle();

    // add $5 in EX, then forwarded from MEM
    jr_control = 1; jr_rs = 5; jr_rs_data = 32'hBAD0;
    ex_reg_write = 1; ex_write_reg = 5;
    step("add.ex");
    ex_reg_write = 0; mem_reg_write = 1; mem_write_reg = 5; mem_alu_result = 32'h200;
    wb_reg_write = 1; wb_write_reg = 5; wb_write_data = 32'h300;
    step("add.mem");
    chk("add.pc", pc, 32'h200);
    idle();

    // JR $0 never stalls
    jr_control = 1; jr_rs = 0; jr_rs_data = 0; ex_reg_write = 1; ex_write_reg = 0;
    step("jr0");
    chk("jr0.pc", pc, 32'h0);
    idle();
    jr_control = 1; jr_rs = 7; jr_rs_data = 32'h43;
    step("mis");
    idle();
    chk("mis.pc", pc, 32'h40);
    step("mis.sticky0"); step("mis.sticky1");
    chk("mis.sticky", {31'h0, jr_misaligned}, 32'h1);

    // pc wraps past the top of the address space
    jr_control = 1; jr_rs = 3; jr_rs_data = 32'hFFFF_FFFF;
    step("wrap.jr");
    idle();
    chk("wrap.top", pc, 32'hFFFF_FFFC);
    step("wrap");
    chk("wrap.zero", pc, 32'h0);

    // reset in JR_WAIT, then external stall over a resolvable JR
    jr_control = 1; jr_rs = 9; ex_reg_write = 1; ex_write_reg = 9;
    step("rw.wait");
    #2;
    do_reset();
    idle();
    jr_control = 1; jr_rs = 9; jr_rs_data = 32'h80; stall_in = 1;
    step("rw.stall0"); step("rw.stall1");
    chk("rw.hold", pc, 32'h0);
    stall_in = 0;
    step("rw.go");
    chk("rw.redir", pc, 32'h80);
    idle();

    // random traffic over a narrow register range to provoke matches
    for (int i = 0; i < 1500; i++) begin
      jr_control     = ($urandom_range(0, 1) == 1);
      jr_rs          = 5'($urandom_range(0, 3));
      jr_rs_data     = $urandom;
      ex_reg_write   = ($urandom_range(0, 2) == 0);
      ex_write_reg   = 5'($urandom_range(0, 3));
      mem_reg_write  = ($urandom_range(0, 1) == 1);
      mem_mem_read   = mem_reg_write && ($urandom_range(0, 2) == 0);
      mem_write_reg  = 5'($urandom_range(0, 3));
      mem_alu_result = $urandom;
      wb_reg_write   = ($urandom_range(0, 1) == 1);
      wb_write_reg   = 5'($urandom_range(0, 3));
      wb_write_data  = $urandom;
      stall_in       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
